// File: rtl/reg_file_param.sv
// reg_file_param: 2-read/2-write register file with busy scoreboard; define REGFILE_BYPASS_EN for same-edge write-to-read bypass
module reg_file_param #(
  parameter int DATA_W   = 18,
  parameter int ADDR_W   = 4,
  parameter int ZERO_REG = 0
) (
  input  logic                    Clk,
  input  logic                    Rst_n,
  input  logic                    ReadEnable1,
  input  logic                    ReadEnable2,
  input  logic [ADDR_W-1:0]       ReadRegister1,
  input  logic [ADDR_W-1:0]       ReadRegister2,
  output logic [DATA_W-1:0]       ReadData1,
  output logic [DATA_W-1:0]       ReadData2,
  output logic                    ReadValid1,
  output logic                    ReadValid2,
  input  logic                    RegWrite0,
  input  logic                    RegWrite1,
  input  logic [ADDR_W-1:0]       WriteRegister0,
  input  logic [ADDR_W-1:0]       WriteRegister1,
  input  logic [DATA_W-1:0]       WriteData0,
  input  logic [DATA_W-1:0]       WriteData1,
  input  logic                    Reserve,
  input  logic [ADDR_W-1:0]       ReserveRegister,
  output logic [(2**ADDR_W)-1:0]  Busy
);
  localparam int DEPTH = 2**ADDR_W;
  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d, rdata2_q, rdata2_d;
  logic              rvalid1_q, rvalid1_d, rvalid2_q, rvalid2_d;
  // Pipe 1 overrides pipe 0; a same-cycle reservation overrides the clearing write.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      regs_d[i] = (ZERO_REG != 0 && i == 0) ? '0 :
                  (RegWrite1 && WriteRegister1 == ADDR_W'(i)) ? WriteData1 :
                  (RegWrite0 && WriteRegister0 == ADDR_W'(i)) ? WriteData0 : regs_q[i];
      busy_d[i] = (ZERO_REG != 0 && i == 0) ? 1'b0 :
                  (Reserve && ReserveRegister == ADDR_W'(i)) ? 1'b1 :
                  ((RegWrite0 && WriteRegister0 == ADDR_W'(i)) ||
                   (RegWrite1 && WriteRegister1 == ADDR_W'(i))) ? 1'b0 : busy_q[i];
    end
  end
  always_comb begin
`ifdef REGFILE_BYPASS_EN
    rdata1_d = ReadEnable1 ? regs_d[ReadRegister1] : rdata1_q;
    rdata2_d = ReadEnable2 ? regs_d[ReadRegister2] : rdata2_q;
`else
    rdata1_d = ReadEnable1 ? regs_q[ReadRegister1] : rdata1_q;
    rdata2_d = ReadEnable2 ? regs_q[ReadRegister2] : rdata2_q;
`endif
    rvalid1_d = ReadEnable1 ? ~busy_d[ReadRegister1] : rvalid1_q;
    rvalid2_d = ReadEnable2 ? ~busy_d[ReadRegister2] : rvalid2_q;
  end
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      busy_q    <= '0;
      rdata1_q  <= '0;
      rdata2_q  <= '0;
      rvalid1_q <= 1'b0;
      rvalid2_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= regs_d[i];
      busy_q    <= busy_d;
      rdata1_q  <= rdata1_d;
      rdata2_q  <= rdata2_d;
      rvalid1_q <= rvalid1_d;
      rvalid2_q <= rvalid2_d;
    end
  end
  assign ReadData1  = rdata1_q;
  assign ReadData2  = rdata2_q;
  assign ReadValid1 = rvalid1_q;
  assign ReadValid2 = rvalid2_q;
  assign Busy       = busy_q;
endmodule

// File: tb/tb_reg_file_param.sv
// tb_reg_file_param: directed + random checks of reg_file_param (ZERO_REG 0 and 1) against an array model
module tb_reg_file_param;
  localparam int DW = 18, AW = 4, D = 16;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic Clk = 1'b0, Rst_n = 1'b0;
  always #5 Clk = ~Clk;
  logic re1, re2, we0, we1, rsv;
  logic [AW-1:0] ra1, ra2, wa0, wa1, rsva;
  logic [DW-1:0] wd0, wd1;
  logic [1:0][DW-1:0] rd1, rd2;
  logic [1:0] rv1, rv2;
  logic [1:0][D-1:0] bsy;
  int cmp = 0, bad = 0;

  reg_file_param #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(0)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .ReadEnable1(re1), .ReadEnable2(re2),
    .ReadRegister1(ra1), .ReadRegister2(ra2), .ReadData1(rd1[0]), .ReadData2(rd2[0]),
    .ReadValid1(rv1[0]), .ReadValid2(rv2[0]), .RegWrite0(we0), .RegWrite1(we1),
    .WriteRegister0(wa0), .WriteRegister1(wa1), .WriteData0(wd0), .WriteData1(wd1),
    .Reserve(rsv), .ReserveRegister(rsva), .Busy(bsy[0]));
  reg_file_param #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) dut_z (
    .Clk(Clk), .Rst_n(Rst_n), .ReadEnable1(re1), .ReadEnable2(re2),
    .ReadRegister1(ra1), .ReadRegister2(ra2), .ReadData1(rd1[1]), .ReadData2(rd2[1]),
    .ReadValid1(rv1[1]), .ReadValid2(rv2[1]), .RegWrite0(we0), .RegWrite1(we1),
    .WriteRegister0(wa0), .WriteRegister1(wa1), .WriteData0(wd0), .WriteData1(wd1),
    .Reserve(rsv), .ReserveRegister(rsva), .Busy(bsy[1]));

  // Reference state: index 0 models ZERO_REG=0, index 1 models ZERO_REG=1.
  logic [DW-1:0] mem [2][D];
  logic          bz  [2][D];
  logic [DW-1:0] erd1 [2], erd2 [2];
  logic          erv1 [2], erv2 [2];

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    cmp++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      logic [D-1:0] eb;
      for (int r = 0; r < D; r++) eb[r] = bz[k][r];
      chk($sformatf("rd1[z=%0d]", k), 32'(rd1[k]), 32'(erd1[k]));
      chk($sformatf("rv1[z=%0d]", k), 32'(rv1[k]), 32'(erv1[k]));
      chk($sformatf("rd2[z=%0d]", k), 32'(rd2[k]), 32'(erd2[k]));
      chk($sformatf("rv2[z=%0d]", k), 32'(rv2[k]), 32'(erv2[k]));
      chk($sformatf("busy[z=%0d]", k), 32'(bsy[k]), 32'(eb));
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < D; r++) begin mem[k][r] = '0; bz[k][r] = 1'b0; end
      erd1[k] = '0; erd2[k] = '0; erv1[k] = 1'b0; erv2[k] = 1'b0;
    end
  endtask

  task automatic cycle();
    for (int k = 0; k < 2; k++) begin
      logic [DW-1:0] nm [D];
      logic          nb [D];
      bit z;
      z = (k == 1);
      nm = mem[k];
      nb = bz[k];
      if (we0 && !(z && wa0 == 0)) begin nm[wa0] = wd0; nb[wa0] = 1'b0; end
      if (we1 && !(z && wa1 == 0)) begin nm[wa1] = wd1; nb[wa1] = 1'b0; end
      if (rsv && !(z && rsva == 0)) nb[rsva] = 1'b1;
      if (re1) begin erd1[k] = BYP ? nm[ra1] : mem[k][ra1]; erv1[k] = !nb[ra1]; end
      if (re2) begin erd2[k] = BYP ? nm[ra2] : mem[k][ra2]; erv2[k] = !nb[ra2]; end
      mem[k] = nm;
      bz[k] = nb;
    end
    @(posedge Clk);
    #1;
    check_all();
  endtask

  task automatic idle();
    re1 = 0; re2 = 0; we0 = 0; we1 = 0; rsv = 0;
    ra1 = 0; ra2 = 0; wa0 = 0; wa1 = 0; rsva = 0; wd0 = 0; wd1 = 0;
  endtask

  task automatic wr(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (p == 0) begin we0 = 1; wa0 = a; wd0 = d; end
    else begin we1 = 1; wa1 = a; wd1 = d; end
  endtask

  task automatic rd(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    re1 = 1; ra1 = a1; re2 = 1; ra2 = a2;
  endtask

  initial begin
    idle();
    model_reset();
    #2 check_all();
    #10 Rst_n = 1'b1;
    // reset mid-operation
    wr(0, 5, 18'h3FFFF); cycle();
    idle(); rd(5, 5); cycle();
    #3 Rst_n = 1'b0;
    #1 model_reset(); check_all();
    #2 Rst_n = 1'b1;
    idle(); rd(5, 5); cycle();
    // basic write then read, then hold
    idle(); wr(0, 3, 18'h12345); cycle();
    idle(); re1 = 1; ra1 = 3; cycle();
    idle(); ra1 = 5; cycle();
    // dual-write collision
    idle(); wr(0, 7, 18'h00011); wr(1, 7, 18'h00022); cycle();
    idle(); rd(7, 7); cycle();
    // scoreboard
    idle(); rsv = 1; rsva = 9; cycle();
    idle(); rd(9, 9); cycle();
    idle(); wr(1, 9, 18'h0ABCD); cycle();
    idle(); rd(9, 9); cycle();
    idle(); wr(0, 9, 18'h00055); rsv = 1; rsva = 9; re1 = 1; ra1 = 9; cycle();
    idle(); rd(9, 9); cycle();
    // same-edge bypass
    idle(); wr(0, 4, 18'h00001); cycle();
    idle(); wr(1, 4, 18'h00FFF); rd(4, 4); cycle();
    idle(); rd(4, 4); cycle();
    // register 0 writes and reservation
    idle(); wr(0, 0, 18'h2AAAA); rsv = 1; rsva = 0; cycle();
    idle(); rd(0, 0); cycle();
    // randomized traffic with address collisions biased in
    for (int n = 0; n < 400; n++) begin
      idle();
      we0 = 1'($urandom); wa0 = AW'($urandom); wd0 = DW'($urandom);
      we1 = 1'($urandom); wa1 = ($urandom_range(0, 3) == 0) ? wa0 : AW'($urandom); wd1 = DW'($urandom);
      rsv = ($urandom_range(0, 3) == 0);
      rsva = ($urandom_range(0, 2) == 0) ? wa1 : AW'($urandom);
      re1 = 1'($urandom); ra1 = ($urandom_range(0, 2) == 0) ? wa0 : AW'($urandom);
      re2 = 1'($urandom); ra2 = ($urandom_range(0, 2) == 0) ? wa1 : AW'($urandom);
      cycle();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
